fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/fifo_wr_arbiter_rr_picker.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 120 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
//   state_t : arbiter FSM states (IDLE, BURST)
//   clog2   : ceiling log2, used to size grant index and burst counter.
//             Callers derive GRANT_W = clog2(NUM_REQ) and
//             CNT_W = clog2(BURST_MAX)+1 from their own parameters.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational rotate-priority encoder.
//   req_valid  in  : per-requester valid
//   last_grant in  : index of the last granted requester
//   next_grant out : first valid index searching upward from last_grant+1,
//                    wrapping modulo NUM_REQ
//   any_req    out : at least one requester is valid
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GRANT_W = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [GRANT_W-1:0] last_grant,
    output logic [GRANT_W-1:0] next_grant,
    output logic               any_req
);

    always_comb begin
        int unsigned idx;
        idx        = 0;
        next_grant = '0;
        any_req    = 1'b0;
        // Offsets 1..NUM_REQ; the last offset revisits last_grant itself.
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_grant) + i) % NUM_REQ;
            if (!any_req && req_valid[GRANT_W'(idx)]) begin
                any_req    = 1'b1;
                next_grant = GRANT_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// Each grant lasts up to BURST_MAX words; every grant costs one IDLE cycle.
//   clk       in  : write-domain clock
//   rest      in  : synchronous active-high reset
//   req_valid in  : per-requester word valid
//   req_data  in  : packed data, requester i at [i*width +: width]
//   req_ready out : per-requester accept (only the granted one, when !full)
//   full      in  : FIFO full flag
//   wr_en     out : FIFO write enable (combinational, zero latency)
//   wr_data   out : FIFO write data (0 when not writing)
//   grant_id  out : current or last granted requester
//   busy      out : high while in BURST
//   stall_cnt out : saturating count of full-stalled cycles
//                   (present only when ARB_STATS_EN is defined)
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int width     = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                       clk,
    input  logic                       rest,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*width-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       full,
    output logic                       wr_en,
    output logic [width-1:0]           wr_data,
    output logic [clog2(NUM_REQ)-1:0]  grant_id,
    output logic                       busy
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]                stall_cnt
`endif
);

    localparam int GRANT_W = clog2(NUM_REQ);
    localparam int CNT_W   = clog2(BURST_MAX) + 1;

    state_t             state, state_nx;
    logic [GRANT_W-1:0] grant_q, grant_nx, pick;
    logic [CNT_W-1:0]   burst_cnt, cnt_nx;
    logic               any_req;
    logic               g_valid;
    logic               xfer;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GRANT_W)
    ) u_picker (
        .req_valid  (req_valid),
        .last_grant (grant_q),
        .next_grant (pick),
        .any_req    (any_req)
    );

    assign g_valid  = req_valid[grant_q];
    assign xfer     = (state == BURST) && g_valid && !full;
    assign grant_id = grant_q;
    assign busy     = (state == BURST);

    always_ff @(posedge clk) begin
        if (rest) begin
            state     <= IDLE;
            grant_q   <= GRANT_W'(NUM_REQ - 1);
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            grant_q   <= grant_nx;
            burst_cnt <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        grant_nx  = grant_q;
        cnt_nx    = burst_cnt;
        req_ready = '0;
        wr_en     = 1'b0;
        wr_data   = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_nx = pick;
                    cnt_nx   = '0;
                    state_nx = BURST;
                end
            end
            BURST: begin
                req_ready[grant_q] = !full;
                wr_en              = xfer;
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (xfer && grant_q == GRANT_W'(i))
                        wr_data = req_data[i*width +: width];
                end
                // A dropped valid ends the burst early; full alone stalls.
                if (!g_valid) begin
                    state_nx = IDLE;
                end else if (!full) begin
                    if (burst_cnt == CNT_W'(BURST_MAX - 1))
                        state_nx = IDLE;
                    else
                        cnt_nx = burst_cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rest)
            stall_cnt <= '0;
        else if (state == BURST && g_valid && full && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter: a 4-requester/burst-4
// instance (main) and a 2-requester/burst-1 instance (alternation case).
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        rest;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  ready;
    logic        full;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [1:0]  gid;
    logic        busy;

    // two-requester, burst-of-one instance
    logic        rest_b;
    logic [1:0]  valid_b;
    logic [15:0] data_b;
    logic [1:0]  ready_b;
    logic        full_b;
    logic        wr_en_b;
    logic [7:0]  wr_data_b;
    logic [0:0]  gid_b;
    logic        busy_b;

`ifdef ARB_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] stall_cnt_b;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fifo_wr_arbiter #(.NUM_REQ(4), .width(8), .BURST_MAX(4)) dut (
        .clk       (clk),
        .rest      (rest),
        .req_valid (valid),
        .req_data  (data),
        .req_ready (ready),
        .full      (full),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .grant_id  (gid),
        .busy      (busy)
`ifdef ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    fifo_wr_arbiter #(.NUM_REQ(2), .width(8), .BURST_MAX(1)) dut_b (
        .clk       (clk),
        .rest      (rest_b),
        .req_valid (valid_b),
        .req_data  (data_b),
        .req_ready (ready_b),
        .full      (full_b),
        .wr_en     (wr_en_b),
        .wr_data   (wr_data_b),
        .grant_id  (gid_b),
        .busy      (busy_b)
`ifdef ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check main-instance outputs for the current cycle, then advance one clock.
    task automatic step(input string tag, input logic e_wr, input logic [7:0] e_data,
                        input logic e_busy, input logic [1:0] e_gid, input logic [3:0] e_rdy);
        #1;
        check({tag, " wr_en"},     32'(wr_en),   32'(e_wr));
        check({tag, " wr_data"},   32'(wr_data), 32'(e_data));
        check({tag, " busy"},      32'(busy),    32'(e_busy));
        check({tag, " grant_id"},  32'(gid),     32'(e_gid));
        check({tag, " req_ready"}, 32'(ready),   32'(e_rdy));
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input string tag, input logic e_wr, input logic [7:0] e_data,
                          input logic e_gid);
        #1;
        check({tag, " wr_en"},    32'(wr_en_b),   32'(e_wr));
        check({tag, " wr_data"},  32'(wr_data_b), 32'(e_data));
        check({tag, " grant_id"}, 32'(gid_b),     32'(e_gid));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rest  = 1'b1;
        valid = '0;
        full  = 1'b0;
        data  = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rest  = 1'b0;
    endtask

    initial begin
        rest    = 1'b1;
        valid   = '0;
        data    = '0;
        full    = 1'b0;
        rest_b  = 1'b1;
        valid_b = '0;
        data_b  = '0;
        full_b  = 1'b0;

        // Reset values, observed while reset is still held.
        @(posedge clk); #1;
        @(posedge clk); #1;
        step("rst", 1'b0, 8'h00, 1'b0, 2'd3, 4'b0000);
`ifdef ARB_STATS_EN
        check("rst stall_cnt", 32'(stall_cnt), 32'd0);
`endif

        // 1: single requester streams A0..A5 -> bursts of 4, gap, 2 more.
        do_reset();
        valid = 4'b0001;
        data[7:0] = 8'hA0;
        step("t1 idle", 1'b0, 8'h00, 1'b0, 2'd3, 4'b0000);
        for (int w = 0; w < 4; w++) begin
            step("t1 burst1", 1'b1, 8'hA0 + 8'(w), 1'b1, 2'd0, 4'b0001);
            data[7:0] = 8'hA0 + 8'(w + 1);
        end
        step("t1 gap", 1'b0, 8'h00, 1'b0, 2'd0, 4'b0000);
        for (int w = 4; w < 6; w++) begin
            step("t1 burst2", 1'b1, 8'hA0 + 8'(w), 1'b1, 2'd0, 4'b0001);
            data[7:0] = 8'hA0 + 8'(w + 1);
        end
        valid = 4'b0000;
        step("t1 drop", 1'b0, 8'h00, 1'b1, 2'd0, 4'b0001);
        step("t1 idle2", 1'b0, 8'h00, 1'b0, 2'd0, 4'b0000);

        // 2: all requesting -> grants 0,1,2,3,0, four writes each.
        do_reset();
        valid = 4'b1111;
        data  = 32'hB3B2B1B0;
        for (int k = 0; k < 5; k++) begin
            step("t2 arb", 1'b0, 8'h00, 1'b0, 2'((k + 3) % 4), 4'b0000);
            for (int w = 0; w < 4; w++)
                step("t2 burst", 1'b1, 8'hB0 + 8'(k % 4), 1'b1, 2'(k % 4),
                     4'(1 << (k % 4)));
        end
        valid = 4'b0000;
        step("t2 end", 1'b0, 8'h00, 1'b0, 2'd0, 4'b0000);

        // 3: grant 2, full for 3 cycles after the 2nd word.
        do_reset();
        valid = 4'b0100;
        data[23:16] = 8'hC0;
        step("t3 idle", 1'b0, 8'h00, 1'b0, 2'd3, 4'b0000);
        step("t3 w0", 1'b1, 8'hC0, 1'b1, 2'd2, 4'b0100);
        data[23:16] = 8'hC1;
        step("t3 w1", 1'b1, 8'hC1, 1'b1, 2'd2, 4'b0100);
        data[23:16] = 8'hC2;
        full = 1'b1;
        for (int s = 0; s < 3; s++)
            step("t3 stall", 1'b0, 8'h00, 1'b1, 2'd2, 4'b0000);
        full = 1'b0;
        step("t3 w2", 1'b1, 8'hC2, 1'b1, 2'd2, 4'b0100);
        data[23:16] = 8'hC3;
        step("t3 w3", 1'b1, 8'hC3, 1'b1, 2'd2, 4'b0100);
        valid = 4'b0000;
        step("t3 end", 1'b0, 8'h00, 1'b0, 2'd2, 4'b0000);
`ifdef ARB_STATS_EN
        check("t3 stall_cnt", 32'(stall_cnt), 32'd3);
`endif

        // 4: grant 1, valid[1] drops after 2 words, requester 3 takes over.
        do_reset();
        valid = 4'b1010;
        data  = 32'hE000D000;
        step("t4 idle", 1'b0, 8'h00, 1'b0, 2'd3, 4'b0000);
        step("t4 w0", 1'b1, 8'hD0, 1'b1, 2'd1, 4'b0010);
        step("t4 w1", 1'b1, 8'hD0, 1'b1, 2'd1, 4'b0010);
        valid = 4'b1000;
        step("t4 drop", 1'b0, 8'h00, 1'b1, 2'd1, 4'b0010);
        step("t4 arb", 1'b0, 8'h00, 1'b0, 2'd1, 4'b0000);
        step("t4 g3", 1'b1, 8'hE0, 1'b1, 2'd3, 4'b1000);
        valid = 4'b0000;
        step("t4 drop3", 1'b0, 8'h00, 1'b1, 2'd3, 4'b1000);
        step("t4 end", 1'b0, 8'h00, 1'b0, 2'd3, 4'b0000);

        // 5: reset asserted mid-burst with burst_cnt==2.
        do_reset();
        valid = 4'b1111;
        data  = 32'h9382_81F0;
        step("t5 idle", 1'b0, 8'h00, 1'b0, 2'd3, 4'b0000);
        step("t5 w0", 1'b1, 8'hF0, 1'b1, 2'd0, 4'b0001);
        step("t5 w1", 1'b1, 8'hF0, 1'b1, 2'd0, 4'b0001);
        rest = 1'b1;
        @(posedge clk); #1;
        rest = 1'b0;
        step("t5 post", 1'b0, 8'h00, 1'b0, 2'd3, 4'b0000);
        step("t5 regrant", 1'b1, 8'hF0, 1'b1, 2'd0, 4'b0001);
        valid = 4'b0000;

        // 6: NUM_REQ=2, BURST_MAX=1 -> grants alternate, one write per two cycles.
        @(posedge clk); #1;
        @(posedge clk); #1;
        rest_b  = 1'b0;
        valid_b = 2'b11;
        data_b  = 16'hAA55;
        for (int k = 0; k < 4; k++) begin
            step_b("t6 arb", 1'b0, 8'h00, 1'((k + 1) % 2));
            step_b("t6 wr", 1'b1, (k % 2 == 0) ? 8'h55 : 8'hAA, 1'(k % 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
